// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation sequencer: walks the candidate grid in raster order,
// drives the SAD engine one candidate at a time and publishes the minimum SAD and its position.
module sad_search_ctrl #(
    parameter int SEARCH_W = 8,
    parameter int SEARCH_H = 8,
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int SAD_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             sad_go,
    output logic [X_W-1:0]   cand_x,
    output logic [Y_W-1:0]   cand_y,
    input  logic             sad_done,
    input  logic [SAD_W-1:0] sad_value,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [X_W-1:0]   best_x,
    output logic [Y_W-1:0]   best_y
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        CMP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [X_W-1:0]   LAST_X  = X_W'(SEARCH_W - 1);
    localparam logic [Y_W-1:0]   LAST_Y  = Y_W'(SEARCH_H - 1);
    localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

    state_t           state_r;
    logic [SAD_W-1:0] cap_r;
    logic [SAD_W-1:0] run_min_r;
    logic [X_W-1:0]   run_x_r;
    logic [Y_W-1:0]   run_y_r;

    logic [SAD_W-1:0] cmp_min_s;
    logic [X_W-1:0]   cmp_x_s;
    logic [Y_W-1:0]   cmp_y_s;
    logic             last_x_s;
    logic             last_y_s;

    // Running minimum after folding in the captured SAD; strict compare keeps the earlier tie
    always_comb begin
        cmp_min_s = run_min_r;
        cmp_x_s   = run_x_r;
        cmp_y_s   = run_y_r;
        if (cap_r < run_min_r) begin
            cmp_min_s = cap_r;
            cmp_x_s   = cand_x;
            cmp_y_s   = cand_y;
        end else begin
            cmp_min_s = run_min_r;
            cmp_x_s   = run_x_r;
            cmp_y_s   = run_y_r;
        end
        last_x_s = (cand_x == LAST_X);
        last_y_s = (cand_y == LAST_Y);
    end

    // Search sequencer with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            sad_go    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cand_x    <= {X_W{1'b0}};
            cand_y    <= {Y_W{1'b0}};
            best_sad  <= SAD_MAX;
            best_x    <= {X_W{1'b0}};
            best_y    <= {Y_W{1'b0}};
            cap_r     <= {SAD_W{1'b0}};
            run_min_r <= SAD_MAX;
            run_x_r   <= {X_W{1'b0}};
            run_y_r   <= {Y_W{1'b0}};
        end else begin
            sad_go <= 1'b0;
            done   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= ISSUE;
                        sad_go    <= 1'b1;
                        busy      <= 1'b1;
                        cand_x    <= {X_W{1'b0}};
                        cand_y    <= {Y_W{1'b0}};
                        run_min_r <= SAD_MAX;
                        run_x_r   <= {X_W{1'b0}};
                        run_y_r   <= {Y_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else if (sad_done) begin
                        cap_r   <= sad_value;
                        state_r <= CMP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                CMP: begin
                    if (abort) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        run_min_r <= cmp_min_s;
                        run_x_r   <= cmp_x_s;
                        run_y_r   <= cmp_y_s;
                        if (last_x_s && last_y_s) begin
                            // Load best_* from the just-folded minimum so they are valid with done
                            state_r  <= FINISH;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            best_sad <= cmp_min_s;
                            best_x   <= cmp_x_s;
                            best_y   <= cmp_y_s;
                        end else if (last_x_s) begin
                            state_r <= ISSUE;
                            sad_go  <= 1'b1;
                            cand_x  <= {X_W{1'b0}};
                            cand_y  <= cand_y + 1'b1;
                        end else begin
                            state_r <= ISSUE;
                            sad_go  <= 1'b1;
                            cand_x  <= cand_x + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Randomized bench for sad_search_ctrl: a cycle-level engine model answers each go,
// and a raster-order minimum search computed from the SAD table predicts the results.
module tb_sad_search_ctrl;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        sad_go;
    logic [3:0]  cand_x;
    logic [3:0]  cand_y;
    logic        sad_done;
    logic [31:0] sad_value;
    logic        busy;
    logic        done;
    logic [31:0] best_sad;
    logic [3:0]  best_x;
    logic [3:0]  best_y;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] tbl [N];
    logic [31:0] m_best_sad;
    int          m_bx;
    int          m_by;

    sad_search_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sad_go(sad_go), .cand_x(cand_x), .cand_y(cand_y),
        .sad_done(sad_done), .sad_value(sad_value),
        .busy(busy), .done(done),
        .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_best(input string tag);
        check_val({tag, "_sad"}, 64'(best_sad), 64'(m_best_sad));
        check_val({tag, "_x"}, 64'(best_x), 64'(m_bx));
        check_val({tag, "_y"}, 64'(best_y), 64'(m_by));
    endtask

    // mode 0: small random SADs (frequent ties), 1: 1000-(x+8y), 2: all-ones
    task automatic run_search(input int mode, input int lat, input bit stray,
                              input int abort_idx, input bit spam);
        int          k, idx, cnt, go_n, ex, ey;
        bit          pending, stray_cmp, finished, aborted, bad;
        logic [31:0] exp_min;
        logic [3:0]  lx, ly;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       tbl[i] = 32'($urandom_range(0, 31));
                1:       tbl[i] = 32'(1000 - i);
                default: tbl[i] = ONES;
            endcase
        end
        exp_min = ONES; ex = 0; ey = 0;
        for (int i = 0; i < N; i++) begin
            if (tbl[i] < exp_min) begin
                exp_min = tbl[i]; ex = i % W; ey = i / W;
            end
        end
        start = 1'b1;
        abort = 1'($urandom_range(0, 1));
        k = cyc;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        idx = 0; go_n = 0; cnt = 0; pending = 0; stray_cmp = 0; finished = 0; aborted = 0;
        lx = 4'd0; ly = 4'd0;
        for (int t = 0; t < 3000 && !finished && !aborted; t++) begin
            sad_done = 1'b0;
            abort    = 1'b0;
            start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            if (stray_cmp) begin
                sad_done = 1'b1; sad_value = 32'd0; stray_cmp = 0;
            end
            if (done) begin
                finished = 1;
                check_val("done_cycle", 64'(cyc), 64'(k + 1 + N * (lat + 2)));
                check_val("done_busy", 64'(busy), 64'd0);
                m_best_sad = exp_min; m_bx = ex; m_by = ey;
                check_best("best");
            end else if (sad_go) begin
                check_val("go_cycle", 64'(cyc), 64'(k + 1 + go_n * (lat + 2)));
                check_val("go_x", 64'(cand_x), 64'(go_n % W));
                check_val("go_y", 64'(cand_y), 64'(go_n / W));
                check_val("go_busy", 64'(busy), 64'd1);
                lx = cand_x; ly = cand_y;
                pending = 1; cnt = lat; go_n++;
                if (stray) begin
                    sad_done = 1'b1; sad_value = 32'd0;
                end
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    check_val("stable_x", 64'(cand_x), 64'(lx));
                    check_val("stable_y", 64'(cand_y), 64'(ly));
                    pending = 0;
                    sad_done = 1'b1;
                    sad_value = tbl[idx];
                    if (idx == abort_idx) begin
                        abort = 1'b1; aborted = 1;
                    end
                    stray_cmp = stray;
                    idx++;
                end
            end
            @(negedge clk);
        end
        sad_done = 1'b0; abort = 1'b0; start = 1'b0;
        if (aborted) begin
            check_val("abort_busy", 64'(busy), 64'd0);
            bad = 0;
            repeat (8) begin
                if (done || sad_go) bad = 1;
                @(negedge clk);
            end
            check_val("abort_quiet", 64'(bad), 64'd0);
            check_best("abort_keep");
        end else if (finished) begin
            check_val("done_pulse", 64'(done), 64'd0);
            check_val("no_restart", 64'(sad_go), 64'd0);
            @(negedge clk);
            check_best("hold");
        end else begin
            check_val("timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_go"}, 64'(sad_go), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_cx"}, 64'(cand_x), 64'd0);
        check_val({tag, "_cy"}, 64'(cand_y), 64'd0);
        m_best_sad = ONES; m_bx = 0; m_by = 0;
        check_best(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; sad_done = 1'b0; sad_value = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b1;
        @(negedge clk);

        run_search(1, 1, 1'b0, -1, 1'b0);
        run_search(0, 5, 1'b1, -1, 1'b1);
        run_search(0, 1, 1'b0, 2, 1'b0);
        run_search(0, 2, 1'b0, -1, 1'b0);

        // asynchronous reset while the engine has not yet answered
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("rst_go", 64'(sad_go), 64'd1);
        repeat (2) @(negedge clk);
        check_val("rst_wait_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_search(2, 1, 1'b0, -1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            run_search(0, $urandom_range(1, 4), 1'($urandom_range(0, 1)), -1,
                       1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
